// File: rtl/turn_timer_ctrl.sv
// rtl/turn_timer_ctrl.sv - two-player turn scheduler driving a shared timeout counter
//
// Purpose:
//    Sequences the external Count timeout counter for a two-player game.
//    Each turn is preceded by a one-cycle LOAD state that reloads Count.
//    The turn passes to the other player on a valid move or on a timeout.
//    Timeout strikes are kept per player, and the game ends at MAX_STRIKES.
//
// Ports:
//    i_clk          system clock, rising edge
//    i_rst          asynchronous active-low reset
//    i_start        1-cycle pulse, begins a game from IDLE or OVER
//    i_abort        1-cycle pulse, returns to IDLE from any state
//    i_press0/1     1-cycle debounced move pulses for player 0 / player 1
//    i_cnt_timeout  Q of Count
//    o_cnt_reload   to Count press; held high outside TURNx
//    o_cnt_enable   1-cycle tick to Count enable, every TICK_DIV turn cycles
//    o_active       player owning the current turn
//    o_turn_on      high in TURN0/TURN1
//    o_move_ack     1-cycle pulse, active player's move accepted
//    o_timeout_evt  1-cycle pulse, active player timed out
//    o_strikes0/1   per-player timeout counts
//    o_game_over    high in OVER
//    o_loser        player that reached MAX_STRIKES, valid while o_game_over
module turn_timer_ctrl #(
   parameter int TICK_DIV     = 50_000_000,
   parameter bit FIRST_PLAYER = 1'b0,
   parameter int MAX_STRIKES  = 3,
   parameter int SW           = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic          i_press0,
   input  logic          i_press1,
   input  logic          i_cnt_timeout,
   output logic          o_cnt_reload,
   output logic          o_cnt_enable,
   output logic          o_active,
   output logic          o_turn_on,
   output logic          o_move_ack,
   output logic          o_timeout_evt,
   output logic [SW-1:0] o_strikes0,
   output logic [SW-1:0] o_strikes1,
   output logic          o_game_over,
   output logic          o_loser
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STRIKE_MAX = SW'(MAX_STRIKES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD0 = 3'd1,
      S_TURN0 = 3'd2,
      S_LOAD1 = 3'd3,
      S_TURN1 = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [PW-1:0] r_presc;
   logic [SW-1:0] r_strikes0;
   logic [SW-1:0] r_strikes1;
   logic          r_active;
   logic          r_loser;
   logic          r_move_ack;
   logic          r_timeout_evt;

   logic          w_in_turn;
   logic          w_turn_player;
   logic          w_press_own;
   logic          w_accept;
   logic          w_timeout;
   logic          w_start_game;
   logic [SW-1:0] w_cur_strikes;
   logic [SW-1:0] w_strike_inc;
   logic          w_strike_out;

   assign w_in_turn     = (r_state == S_TURN0) || (r_state == S_TURN1);
   assign w_turn_player = (r_state == S_TURN1);
   assign w_press_own   = w_turn_player ? i_press1 : i_press0;
   assign w_accept      = w_in_turn && w_press_own;
   // A move in the same cycle as the timeout wins; no strike is charged.
   assign w_timeout     = w_in_turn && i_cnt_timeout && !w_press_own;
   assign w_start_game  = i_start && ((r_state == S_IDLE) || (r_state == S_OVER));
   assign w_cur_strikes = w_turn_player ? r_strikes1 : r_strikes0;
   // Saturating increment: the counter never wraps past MAX_STRIKES.
   assign w_strike_inc  = (w_cur_strikes == STRIKE_MAX) ? w_cur_strikes
                                                        : w_cur_strikes + SW'(1);
   assign w_strike_out  = w_timeout && (w_strike_inc == STRIKE_MAX);

   // Next-state and state-decoded outputs
   always_comb begin
      w_next       = r_state;
      o_cnt_reload = 1'b1;
      o_turn_on    = 1'b0;
      o_game_over  = 1'b0;
      o_cnt_enable = 1'b0;

      case (r_state)
         S_IDLE, S_OVER: begin
            if (i_start) begin
               w_next = FIRST_PLAYER ? S_LOAD1 : S_LOAD0;
            end
            o_game_over = (r_state == S_OVER);
         end
         S_LOAD0: w_next = S_TURN0;
         S_LOAD1: w_next = S_TURN1;
         S_TURN0, S_TURN1: begin
            o_cnt_reload = 1'b0;
            o_turn_on    = 1'b1;
            o_cnt_enable = (r_presc == PRESC_LAST);
            if (w_accept || w_timeout) begin
               if (w_strike_out) begin
                  w_next = S_OVER;
               end else begin
                  w_next = w_turn_player ? S_LOAD0 : S_LOAD1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase

      if (i_abort) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_presc       <= '0;
         r_strikes0    <= '0;
         r_strikes1    <= '0;
         r_active      <= FIRST_PLAYER;
         r_loser       <= 1'b0;
         r_move_ack    <= 1'b0;
         r_timeout_evt <= 1'b0;
      end else begin
         r_state <= w_next;

         if (i_abort) begin
            r_presc       <= '0;
            r_strikes0    <= '0;
            r_strikes1    <= '0;
            r_move_ack    <= 1'b0;
            r_timeout_evt <= 1'b0;
         end else begin
            r_move_ack    <= w_accept;
            r_timeout_evt <= w_timeout;

            // Prescaler runs only in TURNx, so it restarts at 0 in the first turn cycle.
            if (w_in_turn) begin
               r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            end else begin
               r_presc <= '0;
            end

            if (w_start_game) begin
               r_strikes0 <= '0;
               r_strikes1 <= '0;
               r_loser    <= 1'b0;
            end else if (w_timeout) begin
               if (w_turn_player) begin
                  r_strikes1 <= w_strike_inc;
               end else begin
                  r_strikes0 <= w_strike_inc;
               end
               if (w_strike_out) begin
                  r_loser <= w_turn_player;
               end
            end

            if (w_next == S_LOAD0) begin
               r_active <= 1'b0;
            end else if (w_next == S_LOAD1) begin
               r_active <= 1'b1;
            end
         end
      end
   end

   assign o_active      = r_active;
   assign o_move_ack    = r_move_ack;
   assign o_timeout_evt = r_timeout_evt;
   assign o_strikes0    = r_strikes0;
   assign o_strikes1    = r_strikes1;
   assign o_loser       = r_loser;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// tb/tb_turn_timer_ctrl.sv - scoreboard bench for turn_timer_ctrl with a Count model in the loop
module tb_turn_timer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic p0    = 1'b0;
   logic p1    = 1'b0;

   logic       o_cnt_reload, o_cnt_enable, o_active, o_turn_on;
   logic       o_move_ack, o_timeout_evt, o_game_over, o_loser;
   logic [1:0] o_strikes0, o_strikes1;

   // Count model: reload clears; 3 ticks arm it; Q rises one cycle after the third tick lands.
   logic [1:0] c_cnt = 2'd0;
   logic       c_q   = 1'b0;
   always_ff @(posedge clk) begin
      if (o_cnt_reload) begin
         c_cnt <= 2'd0;
         c_q   <= 1'b0;
      end else begin
         if (o_cnt_enable && c_cnt != 2'd3) c_cnt <= c_cnt + 2'd1;
         c_q <= (c_cnt == 2'd3);
      end
   end

   turn_timer_ctrl #(
      .TICK_DIV    (4),
      .FIRST_PLAYER(1'b0),
      .MAX_STRIKES (3),
      .SW          (2)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_abort      (abort),
      .i_press0     (p0),
      .i_press1     (p1),
      .i_cnt_timeout(c_q),
      .o_cnt_reload (o_cnt_reload),
      .o_cnt_enable (o_cnt_enable),
      .o_active     (o_active),
      .o_turn_on    (o_turn_on),
      .o_move_ack   (o_move_ack),
      .o_timeout_evt(o_timeout_evt),
      .o_strikes0   (o_strikes0),
      .o_strikes1   (o_strikes1),
      .o_game_over  (o_game_over),
      .o_loser      (o_loser)
   );

   int n_cmp = 0;
   int n_err = 0;
   int m_s0  = 0;
   int m_s1  = 0;
   int tc    = 0;

   logic [8:0] ev_q[$];
   int         tick_q[$];

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Event word: {timeout_evt, move_ack, active, strikes0, strikes1, game_over, loser}
   function automatic logic [8:0] ev(bit tout, bit act, int s0, int s1, bit over, bit los);
      logic [1:0] a;
      logic [1:0] b;
      a = s0[1:0];
      b = s1[1:0];
      return {tout, ~tout, act, a, b, over, los};
   endfunction

   // Monitor: pops expectations whenever the DUT emits a pulse or a tick
   always @(negedge clk) begin
      if (!rst) tc = 0;
      else if (o_turn_on) tc++;
      else tc = 0;

      if (rst && o_cnt_enable) begin
         if (tick_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tick_unexpected got=turn_cycle_%0d exp=none", tc);
         end else begin
            chk("tick_cycle", tc, tick_q.pop_front());
         end
      end

      if (rst && (o_move_ack || o_timeout_evt)) begin
         if (ev_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pulse_unexpected got=ack%0b/tout%0b exp=none", o_move_ack, o_timeout_evt);
         end else begin
            chk("pulse_event",
                {o_timeout_evt, o_move_ack, o_active, o_strikes0, o_strikes1,
                 o_game_over, o_loser & o_game_over},
                ev_q.pop_front());
         end
      end
   end

   task automatic wait_turn();
      int k = 0;
      while (!o_turn_on && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!o_turn_on) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_turn got=no_turn exp=turn_within_60");
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Player p moves in turn cycle k
   task automatic turn_press(int p, int k);
      wait_turn();
      for (int t = 4; t <= k; t += 4) tick_q.push_back(t);
      repeat (k - 1) @(negedge clk);
      ev_q.push_back(ev(1'b0, (p == 0), m_s0, m_s1, 1'b0, 1'b0));
      if (p == 0) p0 = 1'b1; else p1 = 1'b1;
      @(negedge clk);
      p0 = 1'b0;
      p1 = 1'b0;
   endtask

   // Player p lets the turn run out; returns on the negedge of the pulse cycle
   task automatic turn_timeout(int p);
      bit over;
      int s;
      wait_turn();
      tick_q.push_back(4);
      tick_q.push_back(8);
      tick_q.push_back(12);
      if (p == 0) begin m_s0++; s = m_s0; end
      else        begin m_s1++; s = m_s1; end
      over = (s == 3);
      ev_q.push_back(ev(1'b1, over ? (p == 1) : (p == 0), m_s0, m_s1, over, over ? (p == 1) : 1'b0));
      repeat (14) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      chk("rst_reload", o_cnt_reload, 1);
      chk("rst_pulses", {o_cnt_enable, o_turn_on, o_move_ack, o_timeout_evt, o_game_over, o_loser}, 0);
      chk("rst_active", o_active, 0);
      chk("rst_strikes", {o_strikes0, o_strikes1}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Build up strikes1=2, then reset mid-TURN1
      pulse_start();
      turn_press(0, 1);
      turn_timeout(1);
      turn_press(0, 2);
      turn_timeout(1);
      turn_press(0, 1);
      wait_turn();
      @(negedge clk);
      chk("pre_rst_turn1", {o_turn_on, o_active, o_strikes1}, {1'b1, 1'b1, 2'd2});
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_reload", o_cnt_reload, 1);
      chk("mid_rst_turn_on", o_turn_on, 0);
      chk("mid_rst_strikes", {o_strikes0, o_strikes1}, 0);
      chk("mid_rst_active", o_active, 0);
      m_s0 = 0;
      m_s1 = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Player 0 timeout with ticks at turn cycles 4, 8, 12
      pulse_start();
      chk("load0_state", {o_cnt_reload, o_cnt_enable, o_turn_on, o_active}, {1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      chk("turn0_entry", {o_turn_on, o_cnt_reload}, {1'b1, 1'b0});
      turn_timeout(0);
      chk("after_tout_load1", {o_cnt_reload, o_turn_on, o_active}, {1'b1, 1'b0, 1'b1});

      // Wrong-player press ignored, start ignored in TURN0, own press accepted
      turn_press(1, 2);
      wait_turn();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      p1    = 1'b1;
      @(negedge clk);
      p1 = 1'b0;
      ev_q.push_back(ev(1'b0, 1'b1, m_s0, m_s1, 1'b0, 1'b0));
      p0 = 1'b1;
      @(negedge clk);
      p0 = 1'b0;
      chk("after_move_load1", {o_cnt_reload, o_turn_on, o_active}, {1'b1, 1'b0, 1'b1});

      // Press in the timeout cycle wins
      turn_press(1, 1);
      turn_press(0, 14);

      // Abort during LOAD1 clears strikes; restart lands in LOAD0
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      m_s0  = 0;
      m_s1  = 0;
      chk("abort_idle", {o_cnt_reload, o_turn_on, o_game_over, o_cnt_enable}, {1'b1, 1'b0, 1'b0, 1'b0});
      chk("abort_strikes", {o_strikes0, o_strikes1}, 0);
      pulse_start();
      chk("restart_load0", {o_cnt_reload, o_turn_on, o_active, o_strikes0, o_strikes1}, {1'b1, 1'b0, 1'b0, 4'd0});
      @(negedge clk);
      chk("restart_turn0", o_turn_on, 1);

      // Three timeouts by player 0 end the game
      for (int i = 0; i < 3; i++) begin
         turn_timeout(0);
         if (i < 2) turn_press(1, 2);
      end
      chk("over_flags", {o_game_over, o_loser, o_turn_on, o_cnt_reload}, {1'b1, 1'b0, 1'b0, 1'b1});
      chk("over_strikes0", o_strikes0, 3);
      p0 = 1'b1;
      @(negedge clk);
      p0 = 1'b0;
      p1 = 1'b1;
      @(negedge clk);
      p1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("over_held", {o_game_over, o_strikes0, o_turn_on}, {1'b1, 2'd3, 1'b0});

      // Start from OVER clears strikes
      pulse_start();
      chk("over_restart", {o_game_over, o_strikes0, o_active, o_cnt_reload}, {1'b0, 2'd0, 1'b0, 1'b1});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);

      chk("events_drained", ev_q.size(), 0);
      chk("ticks_drained", tick_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
